mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
// Shares one tagged memory port (MEM_ADDR_BITS address, MEM_TAG_BITS tag) between NUM_REQ
// requesters (e.g. icache, dcache). Arbitration is round-robin.
// Each accepted acquire gets a free outstanding-table slot; the slot index is the downstream tag.
// Each grant is routed back to the owning requester with the requester's original tag restored.
// PARAMETERS
// NUM_REQ          2   number of requesters (2..4)
// ADDR_W          26   address width (= MEM_ADDR_BITS)
// TAG_W            6   tag width (= MEM_TAG_BITS); must satisfy 2**TAG_W >= MAX_OUTSTANDING
// DATA_W          64   single-beat data width
// MAX_OUTSTANDING  4   outstanding-table depth (power of two, 2..16)
// PORTS
// clk             in   1               clock, rising edge
// rst             in   1               asynchronous reset, active-high
// req_valid       in   NUM_REQ         per-requester acquire valid
// req_ready       out  NUM_REQ         per-requester accept (combinational)
// req_type        in   NUM_REQ*3       acquire type (ACQUIRE_* code), slice i = requester i
// req_addr        in   NUM_REQ*ADDR_W  request address
// req_wdata       in   NUM_REQ*DATA_W  put data (single beat)
// req_tag         in   NUM_REQ*TAG_W   requester-local tag
// mem_req_valid   out  1               downstream acquire valid (registered)
// mem_req_ready   in   1               downstream accept
// mem_req_type    out  3               forwarded acquire type
// mem_req_addr    out  ADDR_W          forwarded address
// mem_req_wdata   out  DATA_W          forwarded put data
// mem_req_tag     out  TAG_W           slot index, zero-extended
// mem_resp_valid  in   1               downstream grant valid (no backpressure)
// mem_resp_type   in   3               grant type (GRANT_* code)
// mem_resp_tag    in   TAG_W           slot index being returned
// mem_resp_rdata  in   DATA_W          grant data
// resp_valid      out  NUM_REQ         one-hot grant to owning requester (registered)
// resp_type       out  3               grant type, shared by all requesters
// resp_tag        out  TAG_W           restored requester-local tag
// resp_rdata      out  DATA_W          grant data
// outstanding     out  $clog2(MAX_OUTSTANDING+1)  busy slot count
// err_bad_tag     out  1               sticky: grant arrived for a non-busy or out-of-range slot
// BEHAVIOUR
// - Reset: all outputs 0; every slot free; round-robin pointer = 0; err_bad_tag = 0.
// - Output stage free: stage_free = !mem_req_valid || mem_req_ready.
// - Grant: allowed when stage_free && a slot is free && |req_valid.
//   - Winner: first valid requester at or after rr_ptr, searching modulo NUM_REQ.
//   - req_ready is asserted only for the winner, only in that cycle; at most one bit set.
// - Accept at cycle N:
//   - At N+1 mem_req_* carry the winner's type/addr/wdata and tag = allocated slot.
//   - The slot stores {requester id, req_tag} and is marked busy.
//   - rr_ptr <= winner+1 (mod NUM_REQ).
// - Hold: when mem_req_valid && !mem_req_ready, all mem_req_* fields stay stable.
// - Slot allocation: lowest-index free slot, using free status as of cycle start.
//   - A slot freed in the same cycle is not reusable until the next cycle.
// - Table full (outstanding == MAX_OUTSTANDING): all req_ready = 0; rr_ptr unchanged.
// - Grant return at cycle N, tag of a busy slot:
//   - At N+1, resp_valid[owner] = 1, resp_tag = stored tag, resp_type/rdata = registered copies.
//   - The slot is freed at the end of cycle N.
//   - resp_valid is a single-cycle pulse.
// - Bad tag: a grant with tag >= MAX_OUTSTANDING, or naming a free slot.
//   - Dropped: no resp_valid, table unchanged.
//   - err_bad_tag <= 1 and stays set until reset.
// - outstanding: +1 on accept, -1 on valid free; both in the same cycle = no change.
//   - Never exceeds MAX_OUTSTANDING.
// - Requester deasserts req_valid without ready: allowed; nothing is recorded.
// - Reset mid-operation: table cleared, in-flight mem_req dropped.
//   - Grants for pre-reset tags then raise err_bad_tag.
// TESTING
// 1. Single request: r0 valid, addr 0x000100, tag 5, mem ready=1.
//    -> req_ready[0] same cycle; next cycle mem_req_tag=0, addr 0x000100.
//    -> Grant tag 0: resp_valid=01, resp_tag=5, outstanding 1->0.
// 2. Both requesters valid every cycle, mem ready=1.
//    -> Grants alternate r0,r1,r0,r1.
//    -> Slots 0,1,2,3 allocated, then all req_ready=0 until a grant returns.
// 3. mem_req_ready=0 for 3 cycles with a pending request.
//    -> mem_req_* stable, no further req_ready; on ready=1 a new grant in the same cycle.
// 4. Out-of-order return: grants for slots 2,0,3,1.
//    -> Each routed to its original requester/tag; next allocation takes lowest free slot.
// 5. Grant with tag 7 (MAX_OUTSTANDING=4), then grant on a free slot.
//    -> No resp_valid, err_bad_tag=1 and held; outstanding unchanged.
// 6. Same-cycle free of slot 0 and new accept with table full.
//    -> No accept that cycle; next cycle the accept gets slot 0; outstanding correct.
//    -> Then assert rst mid-traffic: all outputs 0 immediately.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter
//
// Purpose:
//   Shares one tagged memory port between NUM_REQ requesters using round-robin
//   arbitration. Every accepted acquire takes a free slot in an outstanding
//   table. The slot index is the tag sent downstream. When a grant returns,
//   the slot is looked up, the grant is routed to the owning requester with
//   that requester's original tag, and the slot is released.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   i_req_valid         per-requester acquire valid
//   o_req_ready         per-requester accept, combinational, at most one bit set
//   i_req_type/addr/wdata/tag
//                       per-requester acquire fields; slice i belongs to requester i
//   o_mem_req_*         registered downstream acquire (tag = slot index)
//   i_mem_req_ready     downstream accept
//   i_mem_resp_*        downstream grant; there is no backpressure
//   o_resp_valid        registered one-hot grant pulse to the owning requester
//   o_resp_type/tag/rdata
//                       grant fields shared by all requesters, with the tag restored
//   o_outstanding       number of busy slots
//   o_err_bad_tag       sticky flag for a grant whose tag is out of range or names a free slot
// ---------------------------------------------------------------------------
module mem_req_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_W          = 26,
  parameter int TAG_W           = 6,
  parameter int DATA_W          = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   i_req_valid,
  output logic [NUM_REQ-1:0]                   o_req_ready,
  input  logic [NUM_REQ*3-1:0]                 i_req_type,
  input  logic [NUM_REQ*ADDR_W-1:0]            i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]            i_req_wdata,
  input  logic [NUM_REQ*TAG_W-1:0]             i_req_tag,
  output logic                                 o_mem_req_valid,
  input  logic                                 i_mem_req_ready,
  output logic [2:0]                           o_mem_req_type,
  output logic [ADDR_W-1:0]                    o_mem_req_addr,
  output logic [DATA_W-1:0]                    o_mem_req_wdata,
  output logic [TAG_W-1:0]                     o_mem_req_tag,
  input  logic                                 i_mem_resp_valid,
  input  logic [2:0]                           i_mem_resp_type,
  input  logic [TAG_W-1:0]                     i_mem_resp_tag,
  input  logic [DATA_W-1:0]                    i_mem_resp_rdata,
  output logic [NUM_REQ-1:0]                   o_resp_valid,
  output logic [2:0]                           o_resp_type,
  output logic [TAG_W-1:0]                     o_resp_tag,
  output logic [DATA_W-1:0]                    o_resp_rdata,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] o_outstanding,
  output logic                                 o_err_bad_tag
);

  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SLOT_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);

  // Downstream request stage
  logic              r_mem_req_valid;
  logic [2:0]        r_mem_req_type;
  logic [ADDR_W-1:0] r_mem_req_addr;
  logic [DATA_W-1:0] r_mem_req_wdata;
  logic [TAG_W-1:0]  r_mem_req_tag;

  // Response stage
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [2:0]         r_resp_type;
  logic [TAG_W-1:0]   r_resp_tag;
  logic [DATA_W-1:0]  r_resp_rdata;

  // Arbitration and bookkeeping
  logic [ID_W-1:0]  r_rr_ptr;
  logic [CNT_W-1:0] r_outstanding;
  logic             r_err_bad_tag;

  // Outstanding table
  logic [MAX_OUTSTANDING-1:0] r_busy;
  logic [ID_W-1:0]            r_slot_owner [MAX_OUTSTANDING];
  logic [TAG_W-1:0]           r_slot_tag   [MAX_OUTSTANDING];

  // Combinational
  logic               w_stage_free;
  logic               w_found;
  logic [ID_W-1:0]    w_winner;
  int                 w_scan_idx;
  logic               w_slot_avail;
  logic [SLOT_W-1:0]  w_free_slot;
  logic               w_accept;
  logic [2:0]         w_win_type;
  logic [ADDR_W-1:0]  w_win_addr;
  logic [DATA_W-1:0]  w_win_wdata;
  logic [TAG_W-1:0]   w_win_tag;
  logic [ID_W-1:0]    w_rr_next;
  logic               w_resp_in_range;
  logic [SLOT_W-1:0]  w_resp_slot;
  logic               w_resp_hit;
  logic               w_resp_bad;
  logic [NUM_REQ-1:0] w_resp_onehot;
  logic [MAX_OUTSTANDING-1:0] w_slot_set;
  logic [MAX_OUTSTANDING-1:0] w_slot_clr;

  // The stage can take a new request when it is empty or is draining this cycle.
  assign w_stage_free = !r_mem_req_valid || i_mem_req_ready;

  // Round-robin search: the first valid requester at or after r_rr_ptr, modulo NUM_REQ.
  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan_idx = int'(r_rr_ptr) + k;
      if (w_scan_idx >= NUM_REQ) begin
        w_scan_idx = w_scan_idx - NUM_REQ;
      end
      if (!w_found && i_req_valid[w_scan_idx]) begin
        w_found  = 1'b1;
        w_winner = ID_W'(w_scan_idx);
      end
    end
  end

  // Lowest-index free slot. The scan uses the busy bits as they stand at the
  // start of the cycle, so a slot freed by a grant this cycle is not reused
  // until the next cycle.
  always_comb begin
    w_slot_avail = 1'b0;
    w_free_slot  = '0;
    for (int s = MAX_OUTSTANDING - 1; s >= 0; s--) begin
      if (!r_busy[s]) begin
        w_slot_avail = 1'b1;
        w_free_slot  = SLOT_W'(s);
      end
    end
  end

  assign w_accept = w_stage_free && w_slot_avail && w_found;

  assign w_win_type  = i_req_type[w_winner*3 +: 3];
  assign w_win_addr  = i_req_addr[w_winner*ADDR_W +: ADDR_W];
  assign w_win_wdata = i_req_wdata[w_winner*DATA_W +: DATA_W];
  assign w_win_tag   = i_req_tag[w_winner*TAG_W +: TAG_W];

  assign w_rr_next = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

  // Ready is masked during reset so that every output reads zero while rst is high.
  always_comb begin
    o_req_ready = '0;
    if (w_accept && !rst) begin
      o_req_ready[w_winner] = 1'b1;
    end
  end

  // Grant lookup. The range test is one bit wider so that it stays correct
  // when 2**TAG_W equals MAX_OUTSTANDING.
  assign w_resp_in_range = {1'b0, i_mem_resp_tag} < (TAG_W + 1)'(MAX_OUTSTANDING);
  assign w_resp_slot     = i_mem_resp_tag[SLOT_W-1:0];
  assign w_resp_hit      = i_mem_resp_valid && w_resp_in_range && r_busy[w_resp_slot];
  assign w_resp_bad      = i_mem_resp_valid && !w_resp_hit;

  always_comb begin
    w_resp_onehot = '0;
    w_resp_onehot[r_slot_owner[w_resp_slot]] = 1'b1;
  end

  // Per-slot set/clear strobes. Set and clear never target the same slot,
  // because allocation only selects slots that are free at the start of the cycle.
  generate
    for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_slot
      assign w_slot_set[gi] = w_accept && (w_free_slot == SLOT_W'(gi));
      assign w_slot_clr[gi] = w_resp_hit && (w_resp_slot == SLOT_W'(gi));
    end
  endgenerate

  // Outstanding table
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      for (int s = 0; s < MAX_OUTSTANDING; s++) begin
        r_slot_owner[s] <= '0;
        r_slot_tag[s]   <= '0;
      end
    end else begin
      for (int s = 0; s < MAX_OUTSTANDING; s++) begin
        if (w_slot_set[s]) begin
          r_busy[s]       <= 1'b1;
          r_slot_owner[s] <= w_winner;
          r_slot_tag[s]   <= w_win_tag;
        end else if (w_slot_clr[s]) begin
          r_busy[s] <= 1'b0;
        end
      end
    end
  end

  // Downstream request stage and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_req_valid <= 1'b0;
      r_mem_req_type  <= '0;
      r_mem_req_addr  <= '0;
      r_mem_req_wdata <= '0;
      r_mem_req_tag   <= '0;
      r_rr_ptr        <= '0;
    end else begin
      if (w_accept) begin
        r_mem_req_valid <= 1'b1;
        r_mem_req_type  <= w_win_type;
        r_mem_req_addr  <= w_win_addr;
        r_mem_req_wdata <= w_win_wdata;
        r_mem_req_tag   <= TAG_W'(w_free_slot);
        r_rr_ptr        <= w_rr_next;
      end else if (i_mem_req_ready) begin
        // When the stage is held, the payload stays put. Only valid drops once accepted.
        r_mem_req_valid <= 1'b0;
      end
    end
  end

  // Response stage, error flag and busy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid  <= '0;
      r_resp_type   <= '0;
      r_resp_tag    <= '0;
      r_resp_rdata  <= '0;
      r_err_bad_tag <= 1'b0;
      r_outstanding <= '0;
    end else begin
      r_resp_valid <= '0;
      if (w_resp_hit) begin
        r_resp_valid <= w_resp_onehot;
        r_resp_type  <= i_mem_resp_type;
        r_resp_tag   <= r_slot_tag[w_resp_slot];
        r_resp_rdata <= i_mem_resp_rdata;
      end
      if (w_resp_bad) begin
        r_err_bad_tag <= 1'b1;
      end
      case ({w_accept, w_resp_hit})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign o_mem_req_valid = r_mem_req_valid;
  assign o_mem_req_type  = r_mem_req_type;
  assign o_mem_req_addr  = r_mem_req_addr;
  assign o_mem_req_wdata = r_mem_req_wdata;
  assign o_mem_req_tag   = r_mem_req_tag;
  assign o_resp_valid    = r_resp_valid;
  assign o_resp_type     = r_resp_type;
  assign o_resp_tag      = r_resp_tag;
  assign o_resp_rdata    = r_resp_rdata;
  assign o_outstanding   = r_outstanding;
  assign o_err_bad_tag   = r_err_bad_tag;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_req_arbiter
//
// Purpose:
//   Table-driven bench for mem_req_arbiter with NUM_REQ=2 and MAX_OUTSTANDING=4.
//   Each record holds one cycle of stimulus and the outputs expected after it:
//   the combinational ready is checked at the falling edge, and the registered
//   outputs are checked 1 ns after the rising edge. Hand-written sequences
//   cover the reset state and an asynchronous reset that arrives mid-traffic.
// ---------------------------------------------------------------------------
module tb_mem_req_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 26;
  localparam int TAG_W   = 6;
  localparam int DATA_W  = 64;
  localparam int MAXO    = 4;

  localparam logic [ADDR_W-1:0] ADDR0 = 26'h000100;
  localparam logic [ADDR_W-1:0] ADDR1 = 26'h000200;
  localparam logic [2:0]        TYPE0 = 3'd1;
  localparam logic [2:0]        TYPE1 = 3'd4;
  localparam logic [DATA_W-1:0] WD0   = 64'h1111_0000_0000_0100;
  localparam logic [DATA_W-1:0] WD1   = 64'h2222_0000_0000_0200;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        i_req_valid;
  logic [NUM_REQ-1:0]        o_req_ready;
  logic [NUM_REQ*3-1:0]      i_req_type;
  logic [NUM_REQ*ADDR_W-1:0] i_req_addr;
  logic [NUM_REQ*DATA_W-1:0] i_req_wdata;
  logic [NUM_REQ*TAG_W-1:0]  i_req_tag;
  logic                      o_mem_req_valid;
  logic                      i_mem_req_ready;
  logic [2:0]                o_mem_req_type;
  logic [ADDR_W-1:0]         o_mem_req_addr;
  logic [DATA_W-1:0]         o_mem_req_wdata;
  logic [TAG_W-1:0]          o_mem_req_tag;
  logic                      i_mem_resp_valid;
  logic [2:0]                i_mem_resp_type;
  logic [TAG_W-1:0]          i_mem_resp_tag;
  logic [DATA_W-1:0]         i_mem_resp_rdata;
  logic [NUM_REQ-1:0]        o_resp_valid;
  logic [2:0]                o_resp_type;
  logic [TAG_W-1:0]          o_resp_tag;
  logic [DATA_W-1:0]         o_resp_rdata;
  logic [2:0]                o_outstanding;
  logic                      o_err_bad_tag;

  mem_req_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .TAG_W(TAG_W),
    .DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_type(i_req_type), .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata), .i_req_tag(i_req_tag),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_req_type(o_mem_req_type), .o_mem_req_addr(o_mem_req_addr),
    .o_mem_req_wdata(o_mem_req_wdata), .o_mem_req_tag(o_mem_req_tag),
    .i_mem_resp_valid(i_mem_resp_valid), .i_mem_resp_type(i_mem_resp_type),
    .i_mem_resp_tag(i_mem_resp_tag), .i_mem_resp_rdata(i_mem_resp_rdata),
    .o_resp_valid(o_resp_valid), .o_resp_type(o_resp_type),
    .o_resp_tag(o_resp_tag), .o_resp_rdata(o_resp_rdata),
    .o_outstanding(o_outstanding), .o_err_bad_tag(o_err_bad_tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic [1:0] rv;
    logic [5:0] t0;
    logic [5:0] t1;
    logic       mrdy;
    logic       rspv;
    logic [5:0] rtag;
    logic [1:0] e_rdy;
    logic       e_mv;
    logic [5:0] e_mtag;
    logic [25:0] e_maddr;
    logic [1:0] e_rv;
    logic [5:0] e_rtag;
    logic [2:0] e_cnt;
    logic       e_err;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [1:0] rv, input logic [5:0] t0,
                              input logic [5:0] t1, input logic mrdy, input logic rspv,
                              input logic [5:0] rtag, input logic [1:0] e_rdy,
                              input logic e_mv, input logic [5:0] e_mtag,
                              input logic [25:0] e_maddr, input logic [1:0] e_rv,
                              input logic [5:0] e_rtag, input logic [2:0] e_cnt,
                              input logic e_err);
    vec_t v;
    v.rst = r; v.rv = rv; v.t0 = t0; v.t1 = t1; v.mrdy = mrdy; v.rspv = rspv;
    v.rtag = rtag; v.e_rdy = e_rdy; v.e_mv = e_mv; v.e_mtag = e_mtag;
    v.e_maddr = e_maddr; v.e_rv = e_rv; v.e_rtag = e_rtag; v.e_cnt = e_cnt;
    v.e_err = e_err;
    return v;
  endfunction

  initial begin
    vec_t v;
    logic [2:0]        exp_type;
    logic [DATA_W-1:0] exp_wd;

    //           rst rv     t0  t1  mrdy rspv rtag | e_rdy  mv mtag maddr  e_rv   rtag cnt err
    // single request, then its grant
    vecs[0]  = mk(0, 2'b01, 5,  0,  1, 0, 0,   2'b01, 1, 0, ADDR0, 2'b00, 0,  1, 0);
    vecs[1]  = mk(0, 2'b00, 5,  0,  1, 1, 0,   2'b00, 0, 0, ADDR0, 2'b01, 5,  0, 0);
    // reset so that round-robin restarts at requester 0
    vecs[2]  = mk(1, 2'b00, 0,  0,  0, 0, 0,   2'b00, 0, 0, ADDR0, 2'b00, 0,  0, 0);
    // both requesters valid: r0,r1,r0,r1 take slots 0..3, then the table is full
    vecs[3]  = mk(0, 2'b11, 10, 20, 1, 0, 0,   2'b01, 1, 0, ADDR0, 2'b00, 0,  1, 0);
    vecs[4]  = mk(0, 2'b11, 11, 20, 1, 0, 0,   2'b10, 1, 1, ADDR1, 2'b00, 0,  2, 0);
    vecs[5]  = mk(0, 2'b11, 11, 21, 1, 0, 0,   2'b01, 1, 2, ADDR0, 2'b00, 0,  3, 0);
    vecs[6]  = mk(0, 2'b11, 11, 21, 1, 0, 0,   2'b10, 1, 3, ADDR1, 2'b00, 0,  4, 0);
    vecs[7]  = mk(0, 2'b11, 11, 21, 1, 0, 0,   2'b00, 0, 0, ADDR0, 2'b00, 0,  4, 0);
    vecs[8]  = mk(0, 2'b11, 11, 21, 1, 0, 0,   2'b00, 0, 0, ADDR0, 2'b00, 0,  4, 0);
    // out-of-order return of slots 2,0,3 and 1; slot 1 returns alongside a new accept
    vecs[9]  = mk(0, 2'b00, 0,  0,  1, 1, 2,   2'b00, 0, 0, ADDR0, 2'b01, 11, 3, 0);
    vecs[10] = mk(0, 2'b00, 0,  0,  1, 1, 0,   2'b00, 0, 0, ADDR0, 2'b01, 10, 2, 0);
    vecs[11] = mk(0, 2'b00, 0,  0,  1, 1, 3,   2'b00, 0, 0, ADDR0, 2'b10, 21, 1, 0);
    vecs[12] = mk(0, 2'b10, 0,  22, 1, 1, 1,   2'b10, 1, 0, ADDR1, 2'b10, 20, 1, 0);
    // downstream backpressure for 3 cycles, then a grant in the cycle it is released
    vecs[13] = mk(0, 2'b01, 13, 0,  0, 0, 0,   2'b00, 1, 0, ADDR1, 2'b00, 0,  1, 0);
    vecs[14] = mk(0, 2'b01, 13, 0,  0, 0, 0,   2'b00, 1, 0, ADDR1, 2'b00, 0,  1, 0);
    vecs[15] = mk(0, 2'b01, 13, 0,  0, 0, 0,   2'b00, 1, 0, ADDR1, 2'b00, 0,  1, 0);
    vecs[16] = mk(0, 2'b01, 13, 0,  1, 0, 0,   2'b01, 1, 1, ADDR0, 2'b00, 0,  2, 0);
    vecs[17] = mk(0, 2'b00, 0,  0,  1, 0, 0,   2'b00, 0, 0, ADDR0, 2'b00, 0,  2, 0);
    // bad tags: out of range, then a free slot; then a good grant while the flag stays set
    vecs[18] = mk(0, 2'b00, 0,  0,  1, 1, 7,   2'b00, 0, 0, ADDR0, 2'b00, 0,  2, 1);
    vecs[19] = mk(0, 2'b00, 0,  0,  1, 1, 2,   2'b00, 0, 0, ADDR0, 2'b00, 0,  2, 1);
    vecs[20] = mk(0, 2'b00, 0,  0,  1, 1, 0,   2'b00, 0, 0, ADDR0, 2'b10, 22, 1, 1);
    // refill to full, free slot 0 while full (no accept), then reuse slot 0
    vecs[21] = mk(0, 2'b11, 14, 23, 1, 0, 0,   2'b10, 1, 0, ADDR1, 2'b00, 0,  2, 1);
    vecs[22] = mk(0, 2'b11, 14, 23, 1, 0, 0,   2'b01, 1, 2, ADDR0, 2'b00, 0,  3, 1);
    vecs[23] = mk(0, 2'b11, 14, 23, 1, 0, 0,   2'b10, 1, 3, ADDR1, 2'b00, 0,  4, 1);
    vecs[24] = mk(0, 2'b11, 14, 23, 1, 1, 0,   2'b00, 0, 0, ADDR0, 2'b10, 23, 3, 1);
    vecs[25] = mk(0, 2'b11, 14, 23, 1, 0, 0,   2'b01, 1, 0, ADDR0, 2'b00, 0,  4, 1);

    // Static requester fields
    i_req_type  = {TYPE1, TYPE0};
    i_req_addr  = {ADDR1, ADDR0};
    i_req_wdata = {WD1, WD0};
    i_req_tag   = '0;
    i_req_valid = '0;
    i_mem_req_ready  = 1'b0;
    i_mem_resp_valid = 1'b0;
    i_mem_resp_type  = 3'd2;
    i_mem_resp_tag   = '0;
    i_mem_resp_rdata = '0;
    rst = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(o_req_ready), 64'(2'b00));
    chk("rst_mem_valid", 64'(o_mem_req_valid), 64'(1'b0));
    chk("rst_mem_tag", 64'(o_mem_req_tag), 64'(0));
    chk("rst_resp_valid", 64'(o_resp_valid), 64'(2'b00));
    chk("rst_outstanding", 64'(o_outstanding), 64'(0));
    chk("rst_err", 64'(o_err_bad_tag), 64'(1'b0));
    $display("reset: mv=%b rsp=%b cnt=%0d err=%b", o_mem_req_valid, o_resp_valid,
             o_outstanding, o_err_bad_tag);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      rst              = v.rst;
      i_req_valid      = v.rv;
      i_req_tag        = {v.t1, v.t0};
      i_mem_req_ready  = v.mrdy;
      i_mem_resp_valid = v.rspv;
      i_mem_resp_tag   = v.rtag;
      i_mem_resp_type  = 3'd2;
      i_mem_resp_rdata = 64'hD0 + 64'(v.rtag);
      @(negedge clk);
      chk("req_ready", 64'(o_req_ready), 64'(v.e_rdy));
      @(posedge clk);
      #1;
      chk("mem_req_valid", 64'(o_mem_req_valid), 64'(v.e_mv));
      if (v.e_mv) begin
        exp_type = (v.e_maddr == ADDR0) ? TYPE0 : TYPE1;
        exp_wd   = (v.e_maddr == ADDR0) ? WD0 : WD1;
        chk("mem_req_tag", 64'(o_mem_req_tag), 64'(v.e_mtag));
        chk("mem_req_addr", 64'(o_mem_req_addr), 64'(v.e_maddr));
        chk("mem_req_type", 64'(o_mem_req_type), 64'(exp_type));
        chk("mem_req_wdata", o_mem_req_wdata, exp_wd);
      end
      chk("resp_valid", 64'(o_resp_valid), 64'(v.e_rv));
      if (v.e_rv != 2'b00) begin
        chk("resp_tag", 64'(o_resp_tag), 64'(v.e_rtag));
        chk("resp_type", 64'(o_resp_type), 64'(3'd2));
        chk("resp_rdata", o_resp_rdata, 64'hD0 + 64'(v.rtag));
      end
      chk("outstanding", 64'(o_outstanding), 64'(v.e_cnt));
      chk("err_bad_tag", 64'(o_err_bad_tag), 64'(v.e_err));
      $display("vec %0d: rv=%b rdy=%b mv=%b mtag=%0d rsp=%b rtag=%0d cnt=%0d err=%b",
               i, v.rv, o_req_ready, o_mem_req_valid, o_mem_req_tag, o_resp_valid,
               o_resp_tag, o_outstanding, o_err_bad_tag);
    end

    // Asynchronous reset mid-traffic: outputs clear without waiting for a clock edge
    rst              = 1'b0;
    i_req_valid      = 2'b11;
    i_mem_resp_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_mem_valid", 64'(o_mem_req_valid), 64'(1'b0));
    chk("arst_req_ready", 64'(o_req_ready), 64'(2'b00));
    chk("arst_outstanding", 64'(o_outstanding), 64'(0));
    chk("arst_err", 64'(o_err_bad_tag), 64'(1'b0));
    chk("arst_mem_tag", 64'(o_mem_req_tag), 64'(0));
    $display("async reset: mv=%b rdy=%b cnt=%0d err=%b", o_mem_req_valid, o_req_ready,
             o_outstanding, o_err_bad_tag);
    @(posedge clk);
    #1;
    rst              = 1'b0;
    i_req_valid      = 2'b00;
    i_mem_resp_valid = 1'b1;
    i_mem_resp_tag   = 6'd2;
    @(posedge clk);
    #1;
    i_mem_resp_valid = 1'b0;
    chk("stale_resp_valid", 64'(o_resp_valid), 64'(2'b00));
    chk("stale_err", 64'(o_err_bad_tag), 64'(1'b1));
    chk("stale_outstanding", 64'(o_outstanding), 64'(0));
    $display("stale grant tag 2: rsp=%b err=%b cnt=%0d", o_resp_valid, o_err_bad_tag,
             o_outstanding);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
